// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with uart_tx) and the
// oversampling tick positions used to find bit centres.
package uart_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StStart = 2'b01,
      StData  = 2'b10,
      StStop  = 2'b11
   } state_e;

   localparam logic [4:0] OS_MID  = 5'd7;
   localparam logic [4:0] OS_LAST = 5'd15;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 so an idle
// serial line never looks like a start bit coming out of reset.
module sync_2ff (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, DBIT data bits, configurable stop
// length. Reports each frame with a one-cycle done pulse and a framing flag.
import uart_pkg::*;

module uart_rx #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_tick,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       rx_done_tick,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [4:0] SbLast    = 5'(SB_TICK - 1);
   localparam logic [2:0] NLast     = 3'(DBIT - 1);
   localparam int unsigned DoutShift = 8 - DBIT;

   state_e     state_q, state_d;
   logic [4:0] s_q, s_d;
   logic [2:0] n_q, n_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] dout_q, dout_d;
   logic       fe_q, fe_d;
   logic       done_q, done_d;
   logic       rx_s;

   sync_2ff u_sync (
      .clk_i   (clk),
      .reset_i (reset),
      .d_i     (rx),
      .q_o     (rx_s)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      fe_d    = fe_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rx_s) begin
               state_d = StStart;
               s_d     = '0;
            end
         end
         StStart: begin
            if (s_tick) begin
               if (s_q == OS_MID) begin
                  // Line back high at mid-start: treat as a glitch.
                  if (!rx_s) begin
                     state_d = StData;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         StData: begin
            if (s_tick) begin
               if (s_q == OS_LAST) begin
                  s_d     = '0;
                  shift_d = {rx_s, shift_q[7:1]};
                  if (n_q == NLast) begin
                     state_d = StStop;
                  end else begin
                     n_d = n_q + 3'd1;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         StStop: begin
            if (s_tick) begin
               if (s_q == SbLast) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
                  fe_d    = ~rx_s;
                  dout_d  = shift_q >> DoutShift;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         s_q     <= '0;
         n_q     <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         fe_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         fe_q    <= fe_d;
         done_q  <= done_d;
      end
   end

   assign dout         = dout_q;
   assign frame_err    = fe_q;
   assign rx_done_tick = done_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default 8N1 instance plus a DBIT=7, 2-stop
// instance; received frames are captured on the falling clock edge.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_tick;
   logic       rx;
   logic       rx7;
   logic [7:0] dout, dout7;
   logic       done, done7;
   logic       fe, fe7;
   logic       busy, busy7;

   int         checks = 0;
   int         errors = 0;
   int         div = 1;
   int         cyc = 0;
   int         fall_cyc = 0;
   logic [8:0] q1[$];
   logic [8:0] q7[$];
   int         q7cyc[$];

   always #5 clk = ~clk;

   uart_rx u_dut (
      .clk          (clk),
      .reset        (reset),
      .s_tick       (s_tick),
      .rx           (rx),
      .dout         (dout),
      .rx_done_tick (done),
      .frame_err    (fe),
      .busy         (busy)
   );

   uart_rx #(.DBIT(7), .SB_TICK(32)) u_dut7 (
      .clk          (clk),
      .reset        (reset),
      .s_tick       (s_tick),
      .rx           (rx7),
      .dout         (dout7),
      .rx_done_tick (done7),
      .frame_err    (fe7),
      .busy         (busy7)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) q1.push_back({fe, dout});
      if (done7) begin
         q7.push_back({fe7, dout7});
         q7cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One oversampling tick: div-1 idle clocks then one s_tick clock.
   task automatic ticks(input int n);
      repeat (n) begin
         for (int k = 0; k < div - 1; k++) begin
            s_tick = 1'b0;
            @(negedge clk);
         end
         s_tick = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic set_line(input int which, input logic v);
      if (which == 0) rx = v;
      else rx7 = v;
   endtask

   task automatic send_frame(input logic [7:0] data, input int nbits, input logic stop_v,
                             input int sb, input int which);
      set_line(which, 1'b0);
      fall_cyc = cyc;
      ticks(16);
      for (int i = 0; i < nbits; i++) begin
         set_line(which, data[i]);
         ticks(16);
      end
      set_line(which, stop_v);
      ticks(sb);
      set_line(which, 1'b1);
   endtask

   initial begin
      logic [7:0] v81;
      v81    = 8'h81;
      reset  = 1'b1;
      s_tick = 1'b0;
      rx     = 1'b1;
      rx7    = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_dout", dout, 8'h00);
      check("rst_done", done, 1'b0);
      check("rst_fe", fe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_busy7", busy7, 1'b0);

      // 0x55, 8N1, tick every clock
      ticks(5);
      send_frame(8'h55, 8, 1'b1, 16, 0);
      ticks(20);
      check("f55_cnt", q1.size(), 1);
      check("f55_data", q1[0], {1'b0, 8'h55});
      check("f55_busy", busy, 1'b0);
      q1.delete();

      // 0xA5 with low stop bit, then clean 0x3C
      send_frame(8'hA5, 8, 1'b0, 16, 0);
      ticks(20);
      check("fA5_cnt", q1.size(), 1);
      check("fA5_data", q1[0], {1'b1, 8'hA5});
      check("fA5_fe_hold", fe, 1'b1);
      q1.delete();
      send_frame(8'h3C, 8, 1'b1, 16, 0);
      ticks(20);
      check("f3C_cnt", q1.size(), 1);
      check("f3C_data", q1[0], {1'b0, 8'h3C});
      q1.delete();

      // 4-tick low glitch from idle
      rx = 1'b0;
      ticks(4);
      rx = 1'b1;
      check("glitch_busy", busy, 1'b1);
      ticks(30);
      check("glitch_cnt", q1.size(), 0);
      check("glitch_idle", busy, 1'b0);
      check("glitch_dout", dout, 8'h3C);

      // Back-to-back 0x00, 0xFF with tick every 3 clocks
      div = 3;
      send_frame(8'h00, 8, 1'b1, 16, 0);
      send_frame(8'hFF, 8, 1'b1, 16, 0);
      ticks(20);
      check("b2b_cnt", q1.size(), 2);
      check("b2b_first", q1[0], {1'b0, 8'h00});
      check("b2b_second", q1[1], {1'b0, 8'hFF});
      q1.delete();
      div = 1;

      // Reset during data bit 4 of 0x81
      rx = 1'b0;
      ticks(16);
      for (int i = 0; i < 4; i++) begin
         rx = v81[i];
         ticks(16);
      end
      rx = v81[4];
      ticks(8);
      check("abort_busy_pre", busy, 1'b1);
      reset = 1'b1;
      ticks(1);
      reset = 1'b0;
      rx = 1'b1;
      check("abort_busy", busy, 1'b0);
      check("abort_dout", dout, 8'h00);
      check("abort_fe", fe, 1'b0);
      ticks(200);
      check("abort_cnt", q1.size(), 0);
      send_frame(8'h81, 8, 1'b1, 16, 0);
      ticks(20);
      check("f81_cnt", q1.size(), 1);
      check("f81_data", q1[0], {1'b0, 8'h81});
      q1.delete();

      // Break: line held low for two frame times
      rx = 1'b0;
      ticks(330);
      rx = 1'b1;
      ticks(200);
      check("brk_cnt", q1.size() >= 2, 1'b1);
      check("brk_first", q1[0], {1'b1, 8'h00});
      check("brk_second", q1[1], {1'b1, 8'h00});
      check("brk_idle", busy, 1'b0);
      q1.delete();

      // DBIT=7, two stop bits: 2 sync + 1 idle + 8 start + 7*16 data + 32 stop clocks
      send_frame(8'h5A, 7, 1'b1, 32, 1);
      ticks(20);
      check("d7_cnt", q7.size(), 1);
      check("d7_data", q7[0], {1'b0, 8'h5A});
      check("d7_latency", q7cyc[0] - fall_cyc, 155);
      check("d7_other_quiet", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
